// File: rtl/multi_regs_read_pkg.sv
// mrr_pkg: FSM states, line-type codes and line-type helpers shared by multi_regs_read
package mrr_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, WRITE = 2'd1, WAIT = 2'd2, DISC = 2'd3} state_t;
   localparam logic [1:0] LT_HEAD = 2'b01, LT_BODY = 2'b00, LT_TAIL = 2'b10, LT_SINGLE = 2'b11;
   function automatic logic is_tail(input logic [1:0] t);
      return t == LT_TAIL || t == LT_SINGLE;
   endfunction
   function automatic logic is_head(input logic [1:0] t);
      return t == LT_HEAD || t == LT_SINGLE;
   endfunction
endpackage

// File: rtl/multi_regs_read_if.sv
// multi_regs_read_if: packet-buffer RAM write port plus free-bufid FIFO pop port
interface multi_regs_read_if #(parameter int DW = 134, parameter int BUFID_W = 9, parameter int LINE_AW = 7);
   logic [DW-1:0] ov_wdata;
   logic o_data_wr;
   logic [BUFID_W+LINE_AW-1:0] ov_data_waddr;
   logic i_wdata_ack;
   logic i_bufid_empty;
   logic [BUFID_W-1:0] iv_bufid;
   logic o_bufid_ack;
   modport master(output ov_wdata, o_data_wr, ov_data_waddr, o_bufid_ack, input i_wdata_ack, i_bufid_empty, iv_bufid);
   modport slave(input ov_wdata, o_data_wr, ov_data_waddr, o_bufid_ack, output i_wdata_ack, i_bufid_empty, iv_bufid);
endinterface

// File: rtl/multi_regs_read_flag_bank.sv
// staging_flag_bank: per-register empty flags for the staging ring and overflow detection
module staging_flag_bank #(parameter int NUM_REGS = 2) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic [NUM_REGS-1:0] iv_write_flag,
   input  logic [NUM_REGS-1:0] iv_read,
   output logic [NUM_REGS-1:0] ov_empty,
   output logic o_ovf
);
   // a write landing on a full register that is not being drained this cycle loses data
   assign o_ovf = |(iv_write_flag & ~ov_empty & ~iv_read);
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) ov_empty <= '1;
      else ov_empty <= (ov_empty & ~(iv_write_flag & ~iv_read)) | (iv_read & ~iv_write_flag);
endmodule

// File: rtl/multi_regs_read.sv
// multi_regs_read: drains the staging-register ring into packet-buffer RAM at {bufid, line},
// one bufid per packet, with truncation, stray-line discard and statistics
module multi_regs_read
   import mrr_pkg::*;
#(
   parameter int NUM_REGS = 2,
   parameter int DW = 134,
   parameter int BUFID_W = 9,
   parameter int LINE_AW = 7,
   parameter int CNT_W = 16
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic [NUM_REGS*DW-1:0] iv_data,
   input  logic [NUM_REGS-1:0] iv_write_flag,
   multi_regs_read_if.master bus,
   output logic [BUFID_W-1:0] ov_bufid,
   output logic o_pkt_done,
   output logic [1:0] ov_state,
   output logic [CNT_W-1:0] ov_pkt_cnt,
   output logic [CNT_W-1:0] ov_trunc_cnt,
   output logic [CNT_W-1:0] ov_stray_cnt,
   output logic [CNT_W-1:0] ov_ovf_cnt
);
   localparam int PW = $clog2(NUM_REGS);
   localparam logic [LINE_AW-1:0] LAST_LINE = '1;
   state_t state;
   logic [PW-1:0] rd_ptr, nxt_ptr;
   logic [LINE_AW-1:0] line_cnt, nxt_line;
   logic [NUM_REGS-1:0] empty, rd_oh;
   logic [DW-1:0] cur;
   logic [1:0] cur_t;
   logic trunc, ovf, take, force_tail;
   assign cur = iv_data[int'(rd_ptr)*DW +: DW];
   assign cur_t = cur[DW-1:DW-2];
   assign nxt_ptr = (rd_ptr == PW'(NUM_REGS - 1)) ? '0 : rd_ptr + 1'b1;
   assign nxt_line = line_cnt + 1'b1;
   assign force_tail = nxt_line == LAST_LINE && (cur_t == LT_BODY || cur_t == LT_HEAD);
   // a head in IDLE is only taken once a bufid is available; everything else drains unconditionally
   assign take = !empty[rd_ptr] && (state == WRITE || state == DISC ||
                 (state == IDLE && (!is_head(cur_t) || !bus.i_bufid_empty)));
   assign rd_oh = take ? NUM_REGS'(1) << rd_ptr : '0;
   assign ov_state = state;
   staging_flag_bank #(.NUM_REGS(NUM_REGS)) u_flags (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .iv_write_flag(iv_write_flag),
      .iv_read(rd_oh), .ov_empty(empty), .o_ovf(ovf)
   );
   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         state <= IDLE;
         rd_ptr <= '0;
         line_cnt <= '0;
         trunc <= 1'b0;
         bus.ov_wdata <= '0;
         bus.o_data_wr <= 1'b0;
         bus.ov_data_waddr <= '0;
         bus.o_bufid_ack <= 1'b0;
         ov_bufid <= '0;
         o_pkt_done <= 1'b0;
         ov_pkt_cnt <= '0;
         ov_trunc_cnt <= '0;
         ov_stray_cnt <= '0;
         ov_ovf_cnt <= '0;
      end else begin
         bus.o_bufid_ack <= 1'b0;
         o_pkt_done <= 1'b0;
         if (ovf) ov_ovf_cnt <= ov_ovf_cnt + 1'b1;
         case (state)
            IDLE: if (take) begin
               if (is_head(cur_t)) begin
                  bus.ov_wdata <= cur;
                  bus.o_data_wr <= 1'b1;
                  bus.ov_data_waddr <= {bus.iv_bufid, LINE_AW'(0)};
                  bus.o_bufid_ack <= 1'b1;
                  ov_bufid <= bus.iv_bufid;
                  line_cnt <= '0;
                  trunc <= 1'b0;
                  state <= WAIT;
               end else begin
                  ov_stray_cnt <= ov_stray_cnt + 1'b1;
                  rd_ptr <= nxt_ptr;
               end
            end
            WRITE: if (take) begin
               bus.ov_wdata <= force_tail ? {LT_TAIL, cur[DW-3:0]} : cur;
               bus.o_data_wr <= 1'b1;
               bus.ov_data_waddr <= {ov_bufid, nxt_line};
               line_cnt <= nxt_line;
               trunc <= force_tail;
               state <= WAIT;
            end
            WAIT: if (bus.i_wdata_ack) begin
               bus.o_data_wr <= 1'b0;
               rd_ptr <= nxt_ptr;
               o_pkt_done <= trunc || is_tail(bus.ov_wdata[DW-1:DW-2]);
               if (trunc) begin
                  ov_trunc_cnt <= ov_trunc_cnt + 1'b1;
                  state <= DISC;
               end else if (is_tail(bus.ov_wdata[DW-1:DW-2])) begin
                  ov_pkt_cnt <= ov_pkt_cnt + 1'b1;
                  state <= IDLE;
               end else state <= WRITE;
            end
            DISC: if (take) begin
               rd_ptr <= nxt_ptr;
               if (is_tail(cur_t)) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_multi_regs_read.sv
// tb_multi_regs_read: directed packet scenarios on a 4-register, 4-line-buffer configuration;
// expected RAM writes are queued by the stimulus and checked by an independent monitor
module tb_multi_regs_read;
   localparam int NR = 4, DW = 134, BW = 9, LA = 2, CW = 16;
   typedef struct {
      logic [BW+LA-1:0] a;
      logic [DW-1:0] d;
   } exp_t;
   logic clk = 1'b0, rst_n = 1'b0;
   logic [NR*DW-1:0] data = '0;
   logic [NR-1:0] wflag = '0;
   logic [BW-1:0] bufid;
   logic pkt_done;
   logic [1:0] state;
   logic [CW-1:0] pkt_cnt, trunc_cnt, stray_cnt, ovf_cnt;
   exp_t exp_q[$];
   exp_t e_mon;
   logic [BW-1:0] fifo[$];
   int compared = 0, mismatched = 0, n_back = 0, n_done = 0, n_wr = 0, w0;
   multi_regs_read_if #(.DW(DW), .BUFID_W(BW), .LINE_AW(LA)) bus ();
   multi_regs_read #(.NUM_REGS(NR), .DW(DW), .BUFID_W(BW), .LINE_AW(LA), .CNT_W(CW)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .iv_data(data), .iv_write_flag(wflag), .bus(bus),
      .ov_bufid(bufid), .o_pkt_done(pkt_done), .ov_state(state), .ov_pkt_cnt(pkt_cnt),
      .ov_trunc_cnt(trunc_cnt), .ov_stray_cnt(stray_cnt), .ov_ovf_cnt(ovf_cnt)
   );
   always #5 clk = ~clk;

   function automatic logic [DW-1:0] ln(input logic [1:0] t, input logic [15:0] tag);
      return {t, 116'(0), tag};
   endfunction
   task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] req);
      compared++;
      if (act !== req) begin
         mismatched++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, req);
      end
   endtask
   task automatic refresh();
      bus.i_bufid_empty = fifo.size() == 0;
      bus.iv_bufid = fifo.size() != 0 ? fifo[0] : '0;
   endtask
   task automatic give(input logic [BW-1:0] b);
      fifo.push_back(b);
      refresh();
   endtask
   task automatic expw(input logic [BW+LA-1:0] a, input logic [1:0] t, input logic [15:0] tag);
      exp_q.push_back('{a: a, d: ln(t, tag)});
   endtask
   // upstream pulses the flag in the cycle it loads the register; contents visible the cycle after
   task automatic put(input int k, input logic [1:0] t, input logic [15:0] tag);
      @(negedge clk);
      wflag[k] = 1'b1;
      @(negedge clk);
      wflag[k] = 1'b0;
      data[k*DW +: DW] = ln(t, tag);
      @(negedge clk);
   endtask
   task automatic settle();
      repeat (20) @(negedge clk);
   endtask

   // RAM and FIFO side: acks each write one cycle after it appears, pops the FIFO on o_bufid_ack
   initial begin
      forever begin
         @(negedge clk);
         if (bus.o_bufid_ack) begin
            n_back++;
            if (fifo.size() != 0) void'(fifo.pop_front());
            refresh();
         end
         if (pkt_done) n_done++;
         if (bus.i_wdata_ack) bus.i_wdata_ack = 1'b0;
         else if (bus.o_data_wr) begin
            n_wr++;
            if (exp_q.size() == 0) begin
               compared++;
               mismatched++;
               $display("FAIL unexpected_write: addr %0h data %0h, none expected", bus.ov_data_waddr, bus.ov_wdata);
            end else begin
               e_mon = exp_q.pop_front();
               check("wr_addr", bus.ov_data_waddr, e_mon.a);
               check("wr_data", bus.ov_wdata, e_mon.d);
            end
            bus.i_wdata_ack = 1'b1;
         end
      end
   end

   initial begin
      bus.i_wdata_ack = 1'b0;
      bus.i_bufid_empty = 1'b1;
      bus.iv_bufid = '0;
      repeat (3) @(negedge clk);
      check("rst_state", state, 0);
      check("rst_wr", bus.o_data_wr, 0);
      check("rst_back", bus.o_bufid_ack, 0);
      check("rst_waddr", bus.ov_data_waddr, 0);
      check("rst_wdata", bus.ov_wdata, 0);
      check("rst_bufid", bufid, 0);
      check("rst_done", pkt_done, 0);
      check("rst_cnts", {pkt_cnt, trunc_cnt, stray_cnt, ovf_cnt}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      // three-line packet into regs 0..2
      give(9'h005);
      expw(11'h014, 2'b01, 16'h1001); put(0, 2'b01, 16'h1001);
      expw(11'h015, 2'b00, 16'h1002); put(1, 2'b00, 16'h1002);
      expw(11'h016, 2'b10, 16'h1003); put(2, 2'b10, 16'h1003);
      settle();
      check("s1_pkt_cnt", pkt_cnt, 1);
      check("s1_pops", n_back, 1);
      check("s1_done", n_done, 1);
      check("s1_queue", exp_q.size(), 0);
      // single-line packet in reg 3 at the top bufid
      give(9'h1FF);
      expw(11'h7FC, 2'b11, 16'h2001); put(3, 2'b11, 16'h2001);
      settle();
      check("s2_pkt_cnt", pkt_cnt, 2);
      check("s2_bufid", bufid, 9'h1FF);
      check("s2_state", state, 0);
      check("s2_done", n_done, 2);
      // six-line packet truncated at line 3 with forced tail, lines 5-6 dropped
      give(9'h0A3);
      expw(11'h28C, 2'b01, 16'h3001); put(0, 2'b01, 16'h3001);
      expw(11'h28D, 2'b00, 16'h3002); put(1, 2'b00, 16'h3002);
      expw(11'h28E, 2'b00, 16'h3003); put(2, 2'b00, 16'h3003);
      expw(11'h28F, 2'b10, 16'h3004); put(3, 2'b00, 16'h3004);
      put(0, 2'b00, 16'h3005);
      put(1, 2'b10, 16'h3006);
      settle();
      check("s3_trunc_cnt", trunc_cnt, 1);
      check("s3_pkt_cnt", pkt_cnt, 2);
      check("s3_done", n_done, 3);
      check("s3_state", state, 0);
      check("s3_queue", exp_q.size(), 0);
      give(9'h0B1);
      expw(11'h2C4, 2'b11, 16'h3007); put(2, 2'b11, 16'h3007);
      settle();
      check("s3_next_pkt", pkt_cnt, 3);
      check("s3_pops", n_back, 4);
      // stray body line with no packet open
      give(9'h0C2);
      put(3, 2'b00, 16'h4001);
      settle();
      check("s4_stray_cnt", stray_cnt, 1);
      check("s4_no_pop", n_back, 4);
      expw(11'h308, 2'b11, 16'h4002); put(0, 2'b11, 16'h4002);
      settle();
      check("s4_pkt_cnt", pkt_cnt, 4);
      check("s4_pops", n_back, 5);
      // head waits while the bufid FIFO is empty
      expw(11'h044, 2'b01, 16'h5001); put(1, 2'b01, 16'h5001);
      w0 = n_wr;
      repeat (10) @(negedge clk);
      check("s5_no_wr", n_wr, w0);
      check("s5_wr_low", bus.o_data_wr, 0);
      give(9'h011);
      @(negedge clk);
      check("s5_wr_next", bus.o_data_wr, 1);
      expw(11'h045, 2'b10, 16'h5002); put(2, 2'b10, 16'h5002);
      settle();
      check("s5_pkt_cnt", pkt_cnt, 5);
      check("s5_pops", n_back, 6);
      // overflow on reg 0, then a write to reg 0 in the very cycle it is read
      expw(11'h198, 2'b01, 16'h6001); put(3, 2'b01, 16'h6001);
      put(0, 2'b00, 16'h6002);
      expw(11'h199, 2'b00, 16'h6003); put(0, 2'b00, 16'h6003);
      repeat (3) @(negedge clk);
      check("s6_ovf_cnt", ovf_cnt, 1);
      check("s6_wr_low", bus.o_data_wr, 0);
      give(9'h066);
      @(negedge clk);
      @(negedge clk);
      wflag[0] = 1'b1;
      @(negedge clk);
      wflag[0] = 1'b0;
      data[0 +: DW] = ln(2'b11, 16'h6005);
      expw(11'h19A, 2'b10, 16'h6004); put(1, 2'b10, 16'h6004);
      settle();
      check("s6_ovf_hold", ovf_cnt, 1);
      check("s6_pkt_cnt", pkt_cnt, 6);
      give(9'h077); give(9'h088); give(9'h099);
      expw(11'h1DC, 2'b11, 16'h6006);
      expw(11'h220, 2'b11, 16'h6007);
      expw(11'h264, 2'b11, 16'h6005);
      put(2, 2'b11, 16'h6006);
      put(3, 2'b11, 16'h6007);
      settle();
      check("end_pkt_cnt", pkt_cnt, 9);
      check("end_trunc_cnt", trunc_cnt, 1);
      check("end_stray_cnt", stray_cnt, 1);
      check("end_ovf_cnt", ovf_cnt, 1);
      check("end_pops", n_back, 10);
      check("end_done", n_done, 10);
      check("end_queue", exp_q.size(), 0);
      check("end_state", state, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
